// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS main control FSM with retired-instruction counter.
// Define MIPS_MC_JAL_EN to add the jal state and the reg_ra_sel output.
module mips_mc_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic             illegal_op,
`ifdef MIPS_MC_JAL_EN
    output logic             reg_ra_sel,
`endif
    output logic [CNT_W-1:0] instr_retired
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMRD    = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWR    = 4'd5;
    localparam logic [3:0] S_RTYPE_EX = 4'd6;
    localparam logic [3:0] S_RTYPE_WB = 4'd7;
    localparam logic [3:0] S_BEQ      = 4'd8;
    localparam logic [3:0] S_JUMP     = 4'd9;
    localparam logic [3:0] S_ADDI_EX  = 4'd10;
    localparam logic [3:0] S_ADDI_WB  = 4'd11;
    localparam logic [3:0] S_JAL      = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       bad_op;
    logic       retire;

    assign state = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        bad_op  = 1'b0;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPE_EX;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EX;
`ifdef MIPS_MC_JAL_EN
                    OP_JAL:       state_d = S_JAL;
`endif
                    default: begin
                        state_d = S_FETCH;
                        bad_op  = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:    state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_RTYPE_EX: state_d = S_RTYPE_WB;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Retirement happens on the edge that leaves the instruction's last state.
    always_comb begin
        case (state_q)
            S_MEMWB, S_RTYPE_WB, S_BEQ, S_JUMP, S_ADDI_WB: retire = 1'b1;
`ifdef MIPS_MC_JAL_EN
            S_JAL:   retire = 1'b1;
`endif
            S_MEMWR: retire = mem_ready;
            default: retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_retired <= '0;
            illegal_op    <= 1'b0;
        end else begin
            instr_retired <= instr_retired + CNT_W'(retire);
            illegal_op    <= bad_op;
        end
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
`ifdef MIPS_MC_JAL_EN
        reg_ra_sel  = 1'b0;
`endif
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE:   ALUSrcB = 2'b11;
            S_MEMADR, S_ADDI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_RTYPE_EX: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_RTYPE_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_ADDI_WB:  RegWrite = 1'b1;
`ifdef MIPS_MC_JAL_EN
            S_JAL: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                RegWrite   = 1'b1;
                reg_ra_sel = 1'b1;
            end
`endif
            default: ;
        endcase
        // Reset overrides every enable, even the mem_ready-driven ones.
        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_mc_control.sv
// Scoreboard bench for mips_mc_control: instruction-level model
// pushes expected per-cycle outputs, a negedge monitor compares.
module tb_mips_mc_control;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic             MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0]       ALUSrcB, ALUOp, PCSource;
    logic [3:0]       state;
    logic             illegal_op;
    logic             reg_ra_sel;
    logic [CNT_W-1:0] instr_retired;

    mips_mc_control #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .state(state), .illegal_op(illegal_op),
`ifdef MIPS_MC_JAL_EN
        .reg_ra_sel(reg_ra_sel),
`endif
        .instr_retired(instr_retired)
    );

`ifndef MIPS_MC_JAL_EN
    assign reg_ra_sel = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]       st;
        logic [16:0]      ctrl;
        logic             ill;
        logic [CNT_W-1:0] ret;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    logic [CNT_W-1:0] cnt;
    logic pend_ill;

    // Control word expected in a given state, from the state table.
    function automatic logic [16:0] ctrl_of(input logic [3:0] st, input logic mr, input logic rst);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, ra;
        logic [1:0] asb, aop, pcs;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, ra} = '0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (st)
            4'd0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
            4'd1:  asb = 2'b11;
            4'd2:  begin asa = 1; asb = 2'b10; end
            4'd3:  begin mrd = 1; iord = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin mwr = 1; iord = 1; end
            4'd6:  begin asa = 1; aop = 2'b10; end
            4'd7:  begin rw = 1; rdst = 1; end
            4'd8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            4'd9:  begin pcw = 1; pcs = 2'b10; end
            4'd10: begin asa = 1; asb = 2'b10; end
            4'd11: rw = 1;
            4'd12: begin pcw = 1; pcs = 2'b10; rw = 1; ra = 1; end
            default: ;
        endcase
        if (rst) {pcw, pcwc, mrd, mwr, irw, rw} = '0;
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, ra};
    endfunction

    task automatic cycle(input int st, input logic mr, input logic rst, input logic [5:0] op);
        exp_t e;
        reset     = rst;
        mem_ready = mr;
        opcode    = op;
        e.st   = 4'(st);
        e.ctrl = ctrl_of(4'(st), mr, rst);
        e.ill  = pend_ill;
        e.ret  = cnt;
        q.push_back(e);
        pend_ill = 1'b0;
        if (rst) cnt = '0;
        @(posedge clk);
        #1;
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One instruction: fw FETCH stalls, mw memory stalls.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        for (int i = 0; i <= fw; i++) cycle(0, (i == fw), 1'b0, 6'($urandom));
        cycle(1, rbit(), 1'b0, op);
        case (op)
            6'b000010: begin cycle(9, rbit(), 0, op); cnt = cnt + 1'b1; end
            6'b000100: begin cycle(8, rbit(), 0, op); cnt = cnt + 1'b1; end
            6'b000000: begin
                cycle(6, rbit(), 0, op); cycle(7, rbit(), 0, op); cnt = cnt + 1'b1;
            end
            6'b001000: begin
                cycle(10, rbit(), 0, op); cycle(11, rbit(), 0, op); cnt = cnt + 1'b1;
            end
            6'b100011: begin
                cycle(2, rbit(), 0, op);
                for (int i = 0; i <= mw; i++) cycle(3, (i == mw), 1'b0, op);
                cycle(4, rbit(), 0, op); cnt = cnt + 1'b1;
            end
            6'b101011: begin
                cycle(2, rbit(), 0, op);
                for (int i = 0; i <= mw; i++) cycle(5, (i == mw), 1'b0, op);
                cnt = cnt + 1'b1;
            end
`ifdef MIPS_MC_JAL_EN
            6'b000011: begin cycle(12, rbit(), 0, op); cnt = cnt + 1'b1; end
`endif
            default: pend_ill = 1'b1;
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [16:0] act;
            e = q.pop_front();
            act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                   RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, reg_ra_sel};
            chk("state", 32'(state), 32'(e.st));
            chk("ctrl", 32'(act), 32'(e.ctrl));
            chk("illegal_op", 32'(illegal_op), 32'(e.ill));
            chk("instr_retired", 32'(instr_retired), 32'(e.ret));
        end
    end

    initial begin
        logic [5:0] ops [8];
        ops[0] = 6'b100011; ops[1] = 6'b101011; ops[2] = 6'b000000;
        ops[3] = 6'b000100; ops[4] = 6'b000010; ops[5] = 6'b001000;
        ops[6] = 6'b000011; ops[7] = 6'b111111;
        reset = 1'b1; mem_ready = 1'b0; opcode = '0;
        cnt = '0; pend_ill = 1'b0;
        @(posedge clk);
        #1;
        cycle(0, 1'b1, 1'b1, 6'h00);
        cycle(0, 1'b1, 1'b1, 6'h3f);

        run_instr(6'b000010, 0, 0);
        run_instr(6'b100011, 2, 1);
        run_instr(6'b000000, 0, 0);
        run_instr(6'b000100, 0, 0);
        run_instr(6'b001000, 0, 0);
        run_instr(6'b101011, 0, 0);
        run_instr(6'b111111, 0, 0);
        run_instr(6'b000011, 0, 0);
        run_instr(6'b101011, 1, 2);

        // Reset held two cycles mid-MEMRD, with mem_ready asserted.
        cycle(0, 1'b1, 1'b0, 6'h15);
        cycle(1, 1'b1, 1'b0, 6'b100011);
        cycle(2, 1'b0, 1'b0, 6'b100011);
        cycle(3, 1'b0, 1'b0, 6'b100011);
        cycle(3, 1'b1, 1'b1, 6'b100011);
        cycle(0, 1'b1, 1'b1, 6'b100011);

        // Counter wrap: 15 jumps reach 15, one more returns to 0.
        for (int i = 0; i < 16; i++) run_instr(6'b000010, 0, 0);
        run_instr(6'b000100, 0, 0);

        for (int n = 0; n < 300; n++) begin
            logic [5:0] op;
            int k;
            k = int'($urandom_range(0, 7));
            op = (k == 7) ? 6'($urandom) : ops[k];
            run_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
            if ($urandom_range(0, 49) == 0) begin
                cycle(0, rbit(), 1'b1, 6'($urandom));
                cycle(0, rbit(), 1'b1, 6'($urandom));
            end
        end

        cycle(0, 1'b0, 1'b0, 6'h00);
        repeat (2) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d expected=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Multi-cycle MIPS main control unit: Moore FSM that sequences the shared datapath (PC, IR, memory, register file, ALU, jump-address unit) one instruction at a time.
- Drives every datapath enable and mux select.
- Stretches memory states until memory acknowledges.
- Keeps a retired-instruction counter.
- Selects the jump-address path ({PC[31:28], instr[25:0], 2'b00}) via PCSource=2'b10.

Parameters:
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- mem_ready  in  1  memory completes current read/write this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if ALU zero (beq).
- IorD  out  1  0 = PC addresses memory, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  regfile write data from MDR.
- RegDst  out  1  1 = rd, 0 = rt.
- RegWrite  out  1  regfile write enable.
- ALUSrcA  out  1  0 = PC, 1 = rs.
- ALUSrcB  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- ALUOp  out  2  00 add, 01 sub, 10 funct-decoded.
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump address.
- state  out  4  current state encoding (debug).
- illegal_op  out  1  one-cycle pulse on unknown opcode.
- instr_retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset:
  - Sampled on rising clk only.
  - Next state = FETCH, instr_retired = 0, illegal_op = 0.
  - While reset is high, all enables (PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite) are forced 0.
  - Reset wins over any state and any mem_ready, including mid-instruction.
- Output style: all outputs are decoded from the state register only (Moore). mem_ready gates only the PCWrite/IRWrite commit in FETCH.
- Unlisted outputs are 0 in each state.
- State encodings and transitions:
  - 0 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=mem_ready. Stay while mem_ready=0; else -> DECODE.
  - 1 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target to ALUOut). Next state by opcode:
    - 100011 lw or 101011 sw -> MEMADR
    - 000000 R-type -> RTYPE_EX
    - 000100 beq -> BEQ
    - 000010 j -> JUMP
    - 001000 addi -> ADDI_EX
    - anything else -> FETCH with illegal_op pulsed for 1 cycle; not counted as retired.
  - 2 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw -> MEMRD, sw -> MEMWR.
  - 3 MEMRD: MemRead=1, IorD=1. Stay until mem_ready, then -> MEMWB.
  - 4 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH (retire).
  - 5 MEMWR: MemWrite=1, IorD=1. Stay until mem_ready, then -> FETCH (retire).
  - 6 RTYPE_EX: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> RTYPE_WB.
  - 7 RTYPE_WB: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH (retire).
  - 8 BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 -> FETCH (retire).
  - 9 JUMP: PCWrite=1, PCSource=10 -> FETCH (retire).
  - 10 ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDI_WB.
  - 11 ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH (retire).
  - Encodings 12-15 unused, recover to FETCH next cycle.
- Latencies with mem_ready always 1, FETCH to FETCH: j/beq 3 cycles, R-type/addi/sw 4, lw 5. Each cycle mem_ready is low adds 1.
- The opcode used for MEMADR's lw/sw choice is the value held at MEMADR; the IR is stable because IRWrite=0 outside FETCH.
- instr_retired:
  - Increments by 1 on the clock edge that leaves a retiring state (including MEMWR only when mem_ready=1).
  - Wraps 2^CNT_W-1 -> 0 silently.
- Never assert MemRead and MemWrite together; never assert PCWrite and PCWriteCond together.

Optional Feature:
- Macro: MIPS_MC_JAL_EN.
- When defined:
  - Opcode 000011 (jal) in DECODE -> state 12 JAL.
  - JAL: PCWrite=1, PCSource=10, RegWrite=1, write-register select forced to $31, write data = PC (already PC+4).
  - Adds port reg_ra_sel (out, 1), high only in JAL; 0 in all other states.
  - JAL -> FETCH (retire, 3 cycles total).
- When undefined: opcode 000011 is illegal (illegal_op pulse), and reg_ra_sel does not exist.

Test Plan:
- Reset held 2 cycles mid-MEMRD, then released with mem_ready=1 -> state=0, enables 0 during reset, instr_retired=0, FETCH asserts MemRead=1 IorD=0.
- Opcode 000010 (j), mem_ready=1 -> states 0,1,9,0; in state 9 PCWrite=1 PCSource=10; instr_retired +1 after 3 cycles.
- Opcode 100011 (lw), mem_ready low 2 cycles in FETCH and 1 cycle in MEMRD -> states 0,0,0,1,2,3,3,4,0; IRWrite high only on the 3rd FETCH cycle; RegWrite=MemtoReg=1 in state 4.
- Back-to-back R-type (000000), beq (000100), addi (001000), sw (101011) -> state sequences 0,1,6,7 / 0,1,8 / 0,1,10,11 / 0,1,2,5; instr_retired=4; PCWriteCond only in state 8.
- Opcode 111111 -> DECODE then FETCH, illegal_op=1 for exactly 1 cycle, instr_retired unchanged. With MIPS_MC_JAL_EN, 000011 -> states 0,1,12 with reg_ra_sel=1, RegWrite=1, PCSource=10.
- instr_retired preset near wrap (CNT_W=4, 15 j instructions then 1 more) -> counter reads 15 then 0.
